hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RST  in  1  asynchronous reset, active-high.
REQ-004 ihit  in  1  instruction memory returned data this cycle.
REQ-005 dhit  in  1  data memory completed access this cycle.
REQ-006 mem_read_m, mem_write_m  in  1 each  MEM-stage data access request.
REQ-007 mem_read_e  in  1  EX-stage instruction is a load.
REQ-008 write_reg_e  in  5  EX-stage destination register.
REQ-009 rs_d, rt_d  in  5 each  ID-stage source registers.
REQ-010 redirect_e  in  1  EX resolved a taken branch, j, jal or jr.
REQ-011 halt_e  in  1  EX-stage instruction is halt.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline latch enables.
REQ-013 if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP, regWEN=0) into the latch.
REQ-014 imemREN, dmemREN, dmemWEN  out  1 each  arbitrated shared-memory requests.
REQ-015 halt  out  1  pipeline fully drained and stopped.
REQ-016 stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-017 States SHALL be RUN, DRAIN, HALTED, held in a registered FSM.
REQ-018 dpend = (mem_read_m | mem_write_m) & ~dhit; adv = ihit & ~dpend when no data request, adv = dhit when data request present.
REQ-019 Arbitration: dmemREN = mem_read_m & state!=HALTED; dmemWEN = mem_write_m & state!=HALTED; imemREN = ~(mem_read_m | mem_write_m) & state==RUN.
REQ-020 ex_mem_en = mem_wb_en = adv in RUN and DRAIN; 0 in HALTED.
REQ-021 Load-use: lu = mem_read_e & write_reg_e!=0 & (write_reg_e==rs_d | write_reg_e==rt_d).
REQ-022 RUN, adv & lu & ~redirect_e: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 (one bubble, one cycle).
REQ-023 RUN, adv & redirect_e: pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1; redirect wins over lu.
REQ-024 RUN, adv, no lu/redirect: pc_en=if_id_en=id_ex_en=1, flushes 0.
REQ-025 ~adv in any state: all enables and flushes 0 (full freeze); no state change.
REQ-026 RUN, adv & halt_e: next state DRAIN, drain counter loaded with 2; pc_en=0, if_id_flush=id_ex_flush=1; halt_e wins over redirect_e and lu.
REQ-027 DRAIN: pc_en=0, if_id_en=id_ex_en=adv with both flushes=adv; counter decrements on each adv; on adv with counter==1 next state HALTED.
REQ-028 HALTED: all enables 0, halt=1, memory requests 0; exits only on RST.
REQ-029 halt SHALL be registered (asserted first cycle in HALTED), 0 otherwise.
REQ-030 stall_cnt increments each cycle where state!=HALTED and (~adv or load-use bubble); saturates at all ones, no wrap.
REQ-031 No combinational path from any flush output back into adv.

Reset
REQ-032 RST SHALL force state=RUN, drain counter=0, stall_cnt=0, halt=0, asynchronously, including mid-DRAIN or in HALTED.
REQ-033 During RST all enables, flushes and memory requests SHALL be 0.

Verification
REQ-034 ihit=1, no data request, lu conditions with write_reg_e=5, rs_d=5 -> one cycle pc_en=0, id_ex_flush=1, stall_cnt=1; next cycle normal advance.
REQ-035 write_reg_e=0 matching rs_d=0 with mem_read_e=1 -> no stall, stall_cnt stays 0.
REQ-036 mem_read_m=1, dhit=0 for 3 cycles then 1 -> 3 frozen cycles, imemREN=0 throughout, dmemREN=1, stall_cnt=3, advance on dhit cycle.
REQ-037 redirect_e=1 with lu=1, adv=1 -> both flushes 1, pc_en=1, no load-use bubble.
REQ-038 halt_e=1 with adv -> DRAIN; two adv cycles (one 2-cycle dhit wait between) -> HALTED, halt=1 next cycle, all enables 0 for 10 cycles.
REQ-039 RST asserted in DRAIN and in HALTED -> immediately halt=0, state RUN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
//
// Central stall/flush controller for a 5-stage pipeline that shares a single
// memory port between instruction fetch and data access. It decides, every
// cycle, which pipeline latches advance, which latches get a bubble, which
// memory request wins the shared port, and it sequences the halt drain.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   ihit              instruction memory returned data this cycle
//   dhit              data memory completed its access this cycle
//   mem_read_m        MEM-stage load request
//   mem_write_m       MEM-stage store request
//   mem_read_e        EX-stage instruction is a load
//   write_reg_e[4:0]  EX-stage destination register
//   rs_d, rt_d[4:0]   ID-stage source registers
//   redirect_e        EX resolved a taken branch / j / jal / jr
//   halt_e            EX-stage instruction is halt
//   pc_en .. mem_wb_en   pipeline latch enables
//   if_id_flush, id_ex_flush  load a NOP bubble into the latch
//   imemREN, dmemREN, dmemWEN arbitrated shared-memory requests
//   halt              registered, high once the pipeline has drained
//   stall_cnt[CNT_W]  saturating count of stalled cycles
//   state_dbg[1:0]    current FSM state (RUN=0, DRAIN=1, HALTED=2)
//
// Handshake: this block has no valid/ready channels. "ihit"/"dhit" act as the
// memory's completion strobes; a request is held by the pipeline (frozen) until
// its strobe arrives, and the whole pipeline advances only on that cycle.
// ---------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic             mem_read_e,
  input  logic [4:0]       write_reg_e,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             redirect_e,
  input  logic             halt_e,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] drain_cnt;

  // -------------------------------------------------------------------------
  // Advance condition. A pending data access owns the shared port, so the
  // pipeline waits for dhit; otherwise it waits for the instruction fetch.
  // Only memory strobes feed adv -- the flush outputs never loop back into it.
  // -------------------------------------------------------------------------
  logic dreq;
  logic adv;
  logic lu;
  logic bubble;

  assign dreq = mem_read_m | mem_write_m;
  assign adv  = dreq ? dhit : ihit;

  // Load-use: the EX load writes a register that ID is about to read.
  // Register 0 is hardwired zero, so it can never create a dependence.
  assign lu = mem_read_e && (write_reg_e != 5'd0) &&
              ((write_reg_e == rs_d) || (write_reg_e == rt_d));

  // The one-cycle load-use bubble; halt and redirect both take priority.
  assign bubble = (state == RUN) && adv && lu && !redirect_e && !halt_e;

  // -------------------------------------------------------------------------
  // Latch enables and flushes. Forced low while RST is high.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!RST && adv) begin
      unique case (state)
        RUN: begin
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (halt_e) begin
            // Stop fetching and squash everything younger than the halt.
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (redirect_e) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded,
            // so a load-use hazard on them is moot.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            // Hold PC and IF/ID, insert one bubble into ID/EX.
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
          end
        end
        DRAIN: begin
          // Older instructions keep flowing out; the front stays bubbles.
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Shared memory arbitration. Data accesses pre-empt instruction fetch;
  // fetch is only issued in RUN since DRAIN no longer needs instructions.
  // -------------------------------------------------------------------------
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    if (!RST) begin
      dmemREN = mem_read_m  && (state != HALTED);
      dmemWEN = mem_write_m && (state != HALTED);
      imemREN = !dreq && (state == RUN);
    end
  end

  // -------------------------------------------------------------------------
  // FSM, drain counter, halt flag and stall counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halt      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (adv && halt_e) begin
            state     <= DRAIN;
            // Two advances flush the halt through MEM and WB.
            drain_cnt <= 2'd2;
          end
        end
        DRAIN: begin
          if (adv) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) begin
              state <= HALTED;
              halt  <= 1'b1;
            end
          end
        end
        HALTED: begin
          halt <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase

      if ((state != HALTED) && (!adv || bubble) &&
          (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state_dbg = state;

endmodule
